// File: rtl/cmd_responder_if.sv
// rtl/cmd_responder_if.sv - command/response bus between UART command controller and responder
interface cmd_responder_if;
   logic [7:0]  i_cmd;
   logic [63:0] i_cmd_data;
   logic        i_cmd_new;
   logic        o_resp_ready;
   logic [63:0] o_resp_data;

   modport master (
      output i_cmd,
      output i_cmd_data,
      output i_cmd_new,
      input  o_resp_ready,
      input  o_resp_data
   );

   modport slave (
      input  i_cmd,
      input  i_cmd_data,
      input  i_cmd_new,
      output o_resp_ready,
      output o_resp_data
   );
endinterface

// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - executes ping/write/read commands against an internal byte FIFO
module cmd_responder #(
   parameter int         DEPTH      = 16,
   parameter logic [7:0] EMPTY_BYTE = 8'hEE
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   cmd_responder_if.slave           cmd_bus,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_overflow,
   output logic                     o_underflow
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [7:0]  CMD_PING  = 8'h70;
   localparam logic [7:0]  CMD_WRITE = 8'h77;
   localparam logic [7:0]  CMD_READ  = 8'h72;

   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_t;

   state_t        r_state;
   logic          r_new_prev;
   logic [7:0]    r_cmd;
   logic [7:0]    r_data;
   logic [7:0]    r_resp_byte;
   logic          r_resp_ready;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          r_underflow;
   logic [7:0]    r_mem [DEPTH];

   logic          w_rise;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic [3:0]    w_cnt4;
   logic [7:0]    w_status;
   logic          w_unused_ok;

   assign w_rise   = cmd_bus.i_cmd_new & ~r_new_prev;
   assign w_full   = (r_count == CNT_FULL);
   assign w_empty  = (r_count == '0);
   assign w_status = {r_overflow, r_underflow, w_full, w_empty, w_cnt4};

   // Only the low data byte carries command payload.
   assign w_unused_ok = &{1'b0, cmd_bus.i_cmd_data[63:8]};

   // The FIFO memory has no reset; a reset during EXEC must not store the byte.
   assign w_push = (r_state == S_EXEC) && (r_cmd == CMD_WRITE) && !w_full && !i_rst;

   generate
      if (AW >= 3) begin : g_cnt_wide
         assign w_cnt4 = r_count[3:0];
      end else begin : g_cnt_narrow
         assign w_cnt4 = {{(3-AW){1'b0}}, r_count};
      end
   endgenerate

   // FIFO storage write port.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_data;
      end
   end

   // Edge detect, two-state command FSM, FIFO pointers and sticky flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_new_prev   <= 1'b0;
         r_cmd        <= 8'h00;
         r_data       <= 8'h00;
         r_resp_byte  <= 8'h00;
         r_resp_ready <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_new_prev <= cmd_bus.i_cmd_new;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_cmd        <= cmd_bus.i_cmd;
                  r_data       <= cmd_bus.i_cmd_data[7:0];
                  r_resp_ready <= 1'b0;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_resp_ready <= 1'b1;
               r_state      <= S_IDLE;
               case (r_cmd)
                  CMD_PING: begin
                     if (r_data != 8'h00) begin
                        r_resp_byte <= r_data;
                     end else begin
                        r_resp_byte <= w_status;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                     end
                  end
                  CMD_WRITE: begin
                     r_resp_byte <= 8'h00;
                     if (!w_full) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        r_count  <= r_count + CNT_ONE;
                     end else begin
                        r_overflow <= 1'b1;
                     end
                  end
                  CMD_READ: begin
                     if (!w_empty) begin
                        r_resp_byte <= r_mem[r_rd_ptr];
                        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                        r_count     <= r_count - CNT_ONE;
                     end else begin
                        r_resp_byte <= EMPTY_BYTE;
                        r_underflow <= 1'b1;
                     end
                  end
                  default: begin
                     r_resp_byte <= 8'h00;
                  end
               endcase
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_bus.o_resp_ready = r_resp_ready;
   assign cmd_bus.o_resp_data  = {56'h0, r_resp_byte};
   assign o_count              = r_count;
   assign o_full               = w_full;
   assign o_empty              = w_empty;
   assign o_overflow           = r_overflow;
   assign o_underflow          = r_underflow;
endmodule
